spi_adc_reader: RTL and testbench

SPI read master that pulls serial samples out of the scope's front-end ADC (16-bit frame: 4 leading zeros, then 12 data bits MSB first). It sits in the acquisition path opposite the DAC write path, on the same system clock. It generates `cs_n` and `sclk`, shifts in `miso`, and presents each completed sample on a parallel bus with a one-cycle valid strobe.

---
 rtl/spi_adc_reader.sv | 171 +++++++++++++++++
 tb/tb_spi_adc_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_reader.sv
// spi_adc_reader: SPI read master for the front-end ADC.
// Drives cs_n/sclk (CPOL=1), shifts miso in on sclk rising edges and
// presents each completed sample with a one-clock valid strobe.
module spi_adc_reader #(
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int HALF_PERIOD  = 2,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 busy,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 lead_err
);

    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int HCW = $clog2(HALF_PERIOD + 1);
    localparam int QCW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        QUIET = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [HCW-1:0]        hp_q, hp_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [QCW-1:0]        quiet_q, quiet_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic [DATA_BITS-1:0]  sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  lead_q, lead_d;

    // Any set bit among the leading (non-data) frame bits; 0 when there are none.
    function automatic logic lead_or(input logic [FRAME_BITS-1:0] s);
        logic r;
        r = 1'b0;
        for (int i = DATA_BITS; i < FRAME_BITS; i++) begin
            r = r | s[i];
        end
        return r;
    endfunction

    // State and datapath registers; reset returns the bus to its idle levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hp_q     <= '0;
            bit_q    <= '0;
            quiet_q  <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            sample_q <= '0;
            valid_q  <= 1'b0;
            lead_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            bit_q    <= bit_d;
            quiet_q  <= quiet_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            lead_q   <= lead_d;
        end
    end

    // Next-state logic: frame sequencing, sclk generation and bit capture.
    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        bit_d    = bit_q;
        quiet_d  = quiet_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        lead_d   = lead_q;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    hp_d    = '0;
                    bit_d   = '0;
                    quiet_d = '0;
                end
            end

            SETUP: begin
                if (hp_q == HCW'(HALF_PERIOD - 1)) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    hp_d    = '0;
                end else begin
                    hp_d = hp_q + HCW'(1);
                end
            end

            SHIFT: begin
                if (bit_q == BCW'(FRAME_BITS)) begin
                    // Final bit was captured on the previous edge: close the frame.
                    state_d  = QUIET;
                    cs_n_d   = 1'b1;
                    sclk_d   = 1'b1;
                    sample_d = shreg_q[DATA_BITS-1:0];
                    lead_d   = lead_or(shreg_q);
                    valid_d  = 1'b1;
                    hp_d     = '0;
                    bit_d    = '0;
                    quiet_d  = '0;
                end else if (hp_q == HCW'(HALF_PERIOD - 1)) begin
                    hp_d   = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising sclk edge: ADC data has been stable for a half period.
                        shreg_d = {shreg_q[FRAME_BITS-2:0], miso};
                        bit_d   = bit_q + BCW'(1);
                    end
                end else begin
                    hp_d = hp_q + HCW'(1);
                end
            end

            QUIET: begin
                if (quiet_q == QCW'(QUIET_CYCLES - 1)) begin
                    quiet_d = '0;
                    if (start) begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                        hp_d    = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    quiet_d = quiet_q + QCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign busy         = (state_q != IDLE);
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign lead_err     = lead_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// tb_spi_adc_reader: scoreboard bench for spi_adc_reader.
// Two instances: default parameters, and HALF_PERIOD=1/QUIET_CYCLES=1.
module tb_spi_adc_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, start2;
    logic        miso, miso2;
    logic        sclk, cs_n, busy, sample_valid, lead_err;
    logic        sclk2, cs_n2, busy2, sample_valid2, lead_err2;
    logic [11:0] sample, sample2;

    spi_adc_reader #(.FRAME_BITS(16), .DATA_BITS(12), .HALF_PERIOD(2), .QUIET_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .miso(miso),
        .sclk(sclk), .cs_n(cs_n), .busy(busy), .sample(sample),
        .sample_valid(sample_valid), .lead_err(lead_err)
    );

    spi_adc_reader #(.FRAME_BITS(16), .DATA_BITS(12), .HALF_PERIOD(1), .QUIET_CYCLES(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .miso(miso2),
        .sclk(sclk2), .cs_n(cs_n2), .busy(busy2), .sample(sample2),
        .sample_valid(sample_valid2), .lead_err(lead_err2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] s;
        logic        le;
        int          cyc;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] adc1[$];
    logic [15:0] adc2[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect1(input logic [11:0] s, input logic le, input int c);
        exp_t e;
        e.s = s; e.le = le; e.cyc = c;
        q1.push_back(e);
    endtask

    task automatic expect2(input logic [11:0] s, input logic le, input int c);
        exp_t e;
        e.s = s; e.le = le; e.cyc = c;
        q2.push_back(e);
    endtask

    // ADC models: load a word when cs_n falls, present the next bit MSB first on each sclk fall.
    int          idx1 = -1, idx2 = -1;
    logic [15:0] w1 = '0, w2 = '0;

    always @(negedge cs_n) begin
        w1   = (adc1.size() > 0) ? adc1.pop_front() : 16'h0000;
        idx1 = 15;
    end
    always @(negedge sclk) begin
        if (!cs_n && idx1 >= 0) begin
            miso = w1[idx1];
            idx1--;
        end
    end

    always @(negedge cs_n2) begin
        w2   = (adc2.size() > 0) ? adc2.pop_front() : 16'h0000;
        idx2 = 15;
    end
    always @(negedge sclk2) begin
        if (!cs_n2 && idx2 >= 0) begin
            miso2 = w2[idx2];
            idx2--;
        end
    end

    // Scoreboard monitors: compare every valid pulse against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sample_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_valid1 actual=%0h required=none (cycle %0d)", sample, cyc);
            end else begin
                e = q1.pop_front();
                check("sample1", sample, e.s);
                check("lead_err1", lead_err, e.le);
                check("valid_cycle1", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sample_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_valid2 actual=%0h required=none (cycle %0d)", sample2, cyc);
            end else begin
                e = q2.pop_front();
                check("sample2", sample2, e.s);
                check("lead_err2", lead_err2, e.le);
                check("valid_cycle2", cyc, e.cyc);
            end
        end
    end

    // Frame-shape monitor for the default instance: cs_n low length, sclk rises,
    // inter-frame gap and busy release.
    int   lowrun = 0, rises = 0, highrun = 0;
    logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            lowrun = 0; rises = 0; highrun = 0;
        end else begin
            if (!cs_n) begin
                lowrun++;
                if (sclk && !prev_sclk) rises++;
            end
            if (cs_n && !prev_cs) begin
                check("cs_low_len", lowrun, 65);
                check("sclk_rises", rises, 16);
                lowrun = 0; rises = 0; highrun = 0;
            end
            if (!cs_n && prev_cs && prev_busy) check("quiet_gap", highrun, 2);
            if (!busy && prev_busy) check("busy_fall", highrun, 2);
            if (cs_n) highrun++;
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        prev_busy = busy;
    end

    task automatic pulse1(output int c);
        @(negedge clk);
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0 || busy || busy2) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_budget", int'(n < bound), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        reset_n = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        miso    = 1'b0;
        miso2   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 1);
        check("rst_busy", busy, 0);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_lead_err", lead_err, 0);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame
        adc1.push_back(16'h0A5C);
        @(negedge clk);
        expect1(12'hA5C, 1'b0, cyc + 66);
        start = 1'b1; c = cyc;
        @(negedge clk); start = 1'b0;
        wait_idle(200);
        check("single_sample_held", sample, 12'hA5C);

        // Leading-bit error
        adc1.push_back(16'h8FFF);
        @(negedge clk);
        expect1(12'hFFF, 1'b1, cyc + 66);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(200);

        // Continuous frames with start held
        adc1.push_back(16'h0001);
        adc1.push_back(16'h0FFF);
        adc1.push_back(16'h0800);
        @(negedge clk);
        c = cyc;
        expect1(12'h001, 1'b0, c + 66);
        expect1(12'hFFF, 1'b0, c + 133);
        expect1(12'h800, 1'b0, c + 200);
        start = 1'b1;
        while (cyc < c + 140) @(negedge clk);
        start = 1'b0;
        wait_idle(400);

        // Start pulses during an active frame are ignored
        adc1.push_back(16'h0555);
        @(negedge clk);
        c = cyc;
        expect1(12'h555, 1'b0, c + 66);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < c + 40) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(200);
        repeat (5) @(negedge clk);
        check("ignored_start_idle", busy, 0);

        // Reset mid-frame
        adc1.push_back(16'h0FFF);
        pulse1(c);
        while (cyc < c + 31) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sclk", sclk, 1);
        check("midrst_busy", busy, 0);
        check("midrst_sample", sample, 0);
        check("midrst_valid", sample_valid, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        adc1.push_back(16'h0123);
        @(negedge clk);
        expect1(12'h123, 1'b0, cyc + 66);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(200);

        // Fast instance: HALF_PERIOD=1, QUIET_CYCLES=1, back-to-back
        adc2.push_back(16'h0ABC);
        adc2.push_back(16'h8123);
        @(negedge clk);
        c = cyc;
        expect2(12'hABC, 1'b0, c + 34);
        expect2(12'h123, 1'b1, c + 68);
        start2 = 1'b1;
        while (cyc < c + 40) @(negedge clk);
        start2 = 1'b0;
        wait_idle(200);

        repeat (5) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
